// File: rtl/ising_dot_engine.sv
// rtl/ising_dot_engine.sv - streaming Ising spin/coupling dot-product engine
// Accumulates sum(sigma[i] ? +J[i] : -J[i]) over LANES elements per beat, with optional early exit.
module ising_dot_engine #(
  parameter int VECTOR_WIDTH = 256,
  parameter int N            = 8,
  parameter int LANES        = 4,
  parameter int SIGNED_J     = 1,
  localparam int ACC_WIDTH   = N + $clog2(VECTOR_WIDTH) + 1,
  localparam int BEATS       = VECTOR_WIDTH / LANES,
  localparam int BCW         = $clog2(BEATS) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [VECTOR_WIDTH-1:0]     i_sigma,
  input  logic signed [ACC_WIDTH-1:0] i_threshold,
  input  logic                        i_early_exit_en,
  input  logic [LANES*N-1:0]          i_j_data,
  input  logic                        i_j_valid,
  output logic                        o_j_ready,
  output logic                        o_busy,
  output logic                        o_done,
  output logic signed [ACC_WIDTH-1:0] o_result,
  output logic                        o_exceeded,
  output logic [BCW-1:0]              o_beats_used
);

  generate
    if (VECTOR_WIDTH % LANES != 0) begin : g_bad_lanes
      $error("ising_dot_engine: LANES must divide VECTOR_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                        r_state;
  logic [VECTOR_WIDTH-1:0]       r_sigma;
  logic signed [ACC_WIDTH-1:0]   r_threshold;
  logic                          r_early_exit_en;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [BCW-1:0]                r_beat_cnt;

  logic signed [ACC_WIDTH-1:0]   w_beat_sum;
  logic signed [ACC_WIDTH-1:0]   w_acc_next;
  logic                          w_over;
  logic                          w_last;
  logic                          w_accept;

  // r_sigma is shifted down one beat at a time, so lane l always reads bit l
  always_comb begin
    logic signed [ACC_WIDTH-1:0] v_elem;
    w_beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (SIGNED_J != 0) v_elem = ACC_WIDTH'($signed(i_j_data[l*N +: N]));
      else               v_elem = ACC_WIDTH'(i_j_data[l*N +: N]);
      if (r_sigma[l]) w_beat_sum = w_beat_sum + v_elem;
      else            w_beat_sum = w_beat_sum - v_elem;
    end
  end

  assign w_acc_next = r_acc + w_beat_sum;
  assign w_over     = (w_acc_next > r_threshold);
  assign w_last     = (r_beat_cnt == BCW'(BEATS - 1));
  assign o_j_ready  = (r_state == S_RUN) && !i_abort;
  assign w_accept   = o_j_ready && i_j_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_sigma         <= '0;
      r_threshold     <= '0;
      r_early_exit_en <= 1'b0;
      r_acc           <= '0;
      r_beat_cnt      <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_result        <= '0;
      o_exceeded      <= 1'b0;
      o_beats_used    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_sigma         <= i_sigma;
            r_threshold     <= i_threshold;
            r_early_exit_en <= i_early_exit_en;
            r_acc           <= '0;
            r_beat_cnt      <= '0;
            o_exceeded      <= 1'b0;
            o_busy          <= 1'b1;
            r_state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_abort) begin
            o_busy       <= 1'b0;
            o_result     <= '0;
            o_exceeded   <= 1'b0;
            o_beats_used <= '0;
            r_state      <= S_IDLE;
          end else if (w_accept) begin
            r_acc      <= w_acc_next;
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_sigma    <= r_sigma >> LANES;
            if (w_last || (r_early_exit_en && w_over)) begin
              o_done       <= 1'b1;
              o_result     <= w_acc_next;
              o_exceeded   <= w_over;
              o_beats_used <= r_beat_cnt + 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
